fetch_unit: RTL and testbench

//  Instruction fetch stage directly downstream of PC. Takes PC.out, reads instruction ROM
//  (sync read, 1-cycle latency), buffers {pc, instr} in a DEPTH-entry queue, offers it to
//  the CPU decode stage over valid/ready. Drives PC.inc; CPU jumps (PC.load) arrive as flush.

---
 rtl/hack_pkg.sv | 10 +
 rtl/fetch_unit_if.sv | 22 ++
 rtl/fetch_unit_fifo.sv | 40 ++++
 rtl/fetch_unit.sv | 78 +++++++
 tb/tb_fetch_unit.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hack_pkg.sv
// hack_pkg: shared widths, ROM timing and the fetch queue entry layout
package hack_pkg;
    localparam int WORD_W      = 16;
    localparam int ADDR_W      = 15;
    localparam int ROM_LATENCY = 1;
    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: PC, ROM and decode-side signals of the fetch stage
interface fetch_unit_if;
    import hack_pkg::*;
    logic [WORD_W-1:0] pc;
    logic              pc_inc;
    logic              flush;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [WORD_W-1:0] rom_data;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_instr;
    logic [WORD_W-1:0] out_pc;
    modport master (
        input  pc, flush, rom_data, out_ready,
        output pc_inc, rom_en, rom_addr, out_valid, out_instr, out_pc
    );
    modport slave (
        output pc, flush, rom_data, out_ready,
        input  pc_inc, rom_en, rom_addr, out_valid, out_instr, out_pc
    );
endinterface

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: shift-register queue whose slot 0 is the registered head; head holds its value when drained
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 32,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          clear_i,
    input  logic [W-1:0]  data_i,
    output logic [W-1:0]  head_o,
    output logic [CW-1:0] count_o
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [CW-1:0] count_q, count_d, idx;
    // shift live entries toward the head on pop, then drop the new entry behind them
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < DEPTH - 1; i++)
            if (pop_i && CW'(i + 1) < count_q) mem_d[i] = mem_q[i + 1];
        idx = count_q - CW'(pop_i);
        if (push_i && idx < CW'(DEPTH)) mem_d[idx[CW-2:0]] = data_i;
        count_d = clear_i ? '0 : count_q + CW'(push_i) - CW'(pop_i);
    end
    // storage and occupancy registers
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end
    assign head_o  = mem_q[0];
    assign count_o = count_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: issues ROM reads on queue credit and delivers {pc, instr}; FETCH_PERF_EN adds perf counters
module fetch_unit
    import hack_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]  perf_fetch,
    output logic [15:0]  perf_stall
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [CW-1:0]     count;
    fetch_entry_t      head, entry;
    logic              inflight_q, inflight_d;
    logic [WORD_W-1:0] tag_q, tag_d;
    logic              valid, pop, push, issue;
    // credit check counts queued plus in-flight entries, freeing the slot a same-cycle pop releases
    always_comb begin
        valid      = ~reset & ~bus.flush & (count != '0);
        pop        = valid & bus.out_ready;
        push       = ~reset & ~bus.flush & inflight_q;
        issue      = ~reset & ~bus.flush & (count + CW'(inflight_q) < CW'(DEPTH) + CW'(pop));
        inflight_d = issue;
        tag_d      = issue ? bus.pc : tag_q;
        entry      = '{pc: tag_q, instr: bus.rom_data};
    end
    // in-flight flag and the PC tag of the outstanding ROM read
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q <= 1'b0;
            tag_q      <= '0;
        end else begin
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
        end
    end
    fetch_fifo #(.DEPTH(DEPTH), .W($bits(fetch_entry_t))) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (bus.flush),
        .data_i  (entry),
        .head_o  (head),
        .count_o (count)
    );
    assign bus.pc_inc    = issue;
    assign bus.rom_en    = issue;
    assign bus.rom_addr  = bus.pc[ADDR_W-1:0];
    assign bus.out_valid = valid;
    assign bus.out_instr = head.instr;
    assign bus.out_pc    = head.pc;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetch_q, perf_fetch_d, perf_stall_q, perf_stall_d;
    // saturating delivery and starvation counters
    always_comb begin
        perf_fetch_d = (pop && perf_fetch_q != 16'hFFFF) ? perf_fetch_q + 16'd1 : perf_fetch_q;
        perf_stall_d = (bus.out_ready && !valid && perf_stall_q != 16'hFFFF) ? perf_stall_q + 16'd1 : perf_stall_q;
    end
    // counters clear on reset only
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
        end
    end
    assign perf_fetch = perf_fetch_q;
    assign perf_stall = perf_stall_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a queue-level model
module tb_fetch_unit;
    import hack_pkg::*;
    localparam int DEPTH = 2;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [WORD_W-1:0] load_val = '0;
    int errors = 0;
    int checks = 0;
    fetch_unit_if bus();
`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetch, perf_stall;
`endif
    fetch_unit #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch (perf_fetch),
        .perf_stall (perf_stall)
`endif
    );
    always #5 clk = ~clk;

    function automatic logic [WORD_W-1:0] rom(input logic [ADDR_W-1:0] a);
        return WORD_W'(a) + 16'h0100;
    endfunction

    // PC register and synchronous ROM around the fetch stage
    always @(posedge clk) begin
        if (reset) bus.pc <= '0;
        else if (bus.flush) bus.pc <= load_val;
        else if (bus.pc_inc) bus.pc <= bus.pc + 16'd1;
        if (bus.rom_en) bus.rom_data <= rom(bus.rom_addr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.flush = 1'b0;
        load_val = '0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.pc_inc !== 1'b0) begin errors++; $display("FAIL reset_pc_inc got=%b exp=0", bus.pc_inc); end
        checks++; if (bus.rom_en !== 1'b0) begin errors++; $display("FAIL reset_rom_en got=%b exp=0", bus.rom_en); end
        checks++; if (bus.out_pc !== 16'h0000) begin errors++; $display("FAIL reset_out_pc got=%h exp=0000", bus.out_pc); end
        checks++; if (bus.out_instr !== 16'h0000) begin errors++; $display("FAIL reset_out_instr got=%h exp=0000", bus.out_instr); end
`ifdef FETCH_PERF_EN
        checks++; if (perf_fetch !== 16'h0) begin errors++; $display("FAIL reset_perf_fetch got=%0d exp=0", perf_fetch); end
        checks++; if (perf_stall !== 16'h0) begin errors++; $display("FAIL reset_perf_stall got=%0d exp=0", perf_stall); end
`endif
        tick();
        reset = 1'b0;
    endtask

    task automatic test_stream();
        do_reset();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++; if (bus.pc_inc !== 1'b1) begin errors++; $display("FAIL stream_pc_inc c=%0d got=%b exp=1", c, bus.pc_inc); end
            checks++; if (bus.out_valid !== (c >= 2)) begin errors++; $display("FAIL stream_valid c=%0d got=%b exp=%b", c, bus.out_valid, c >= 2); end
            if (c >= 2) begin
                checks++; if (bus.out_pc !== 16'(c - 2)) begin errors++; $display("FAIL stream_pc c=%0d got=%h exp=%h", c, bus.out_pc, 16'(c - 2)); end
                checks++; if (bus.out_instr !== 16'h0100 + 16'(c - 2)) begin errors++; $display("FAIL stream_instr c=%0d got=%h exp=%h", c, bus.out_instr, 16'h0100 + 16'(c - 2)); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++; if (bus.pc_inc !== (c < 2)) begin errors++; $display("FAIL bp_pc_inc c=%0d got=%b exp=%b", c, bus.pc_inc, c < 2); end
            checks++; if (bus.pc !== 16'(c < 2 ? c : 2)) begin errors++; $display("FAIL bp_pc_hold c=%0d got=%h exp=%h", c, bus.pc, 16'(c < 2 ? c : 2)); end
            tick();
        end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid c=%0d got=%b exp=1", c, bus.out_valid); end
            checks++; if (bus.pc_inc !== 1'b1) begin errors++; $display("FAIL bp_restart c=%0d got=%b exp=1", c, bus.pc_inc); end
            checks++; if (bus.out_pc !== 16'(c)) begin errors++; $display("FAIL bp_pc c=%0d got=%h exp=%h", c, bus.out_pc, 16'(c)); end
            checks++; if (bus.out_instr !== 16'h0100 + 16'(c)) begin errors++; $display("FAIL bp_instr c=%0d got=%h exp=%h", c, bus.out_instr, 16'h0100 + 16'(c)); end
            tick();
        end
    endtask

    task automatic test_flush();
        do_reset();
        bus.out_ready = 1'b0;
        repeat (2) tick();
        bus.flush = 1'b1;
        load_val = 16'd12345;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0 || bus.pc_inc !== 1'b0) begin errors++; $display("FAIL flush_cycle got valid=%b inc=%b exp 0 0", bus.out_valid, bus.pc_inc); end
        tick();
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_next_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.pc_inc !== 1'b1 || bus.rom_addr !== 15'd12345) begin errors++; $display("FAIL flush_resume got inc=%b addr=%h exp 1 %h", bus.pc_inc, bus.rom_addr, 15'd12345); end
        tick();
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped got=%b exp=0", bus.out_valid); end
        tick();
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 16'd12345) begin errors++; $display("FAIL flush_first_pc got v=%b pc=%0d exp 1 12345", bus.out_valid, bus.out_pc); end
        checks++; if (bus.out_instr !== 16'd12601) begin errors++; $display("FAIL flush_first_instr got=%0d exp=12601", bus.out_instr); end
        do_reset();
        bus.flush = 1'b1;
        load_val = 16'h0040;
        @(negedge clk);
        checks++; if (bus.pc_inc !== 1'b0) begin errors++; $display("FAIL flush_empty_inc got=%b exp=0", bus.pc_inc); end
        tick();
        bus.flush = 1'b0;
        @(negedge clk);
        checks++; if (bus.pc_inc !== 1'b1 || bus.pc !== 16'h0040) begin errors++; $display("FAIL flush_empty_resume got inc=%b pc=%h exp 1 0040", bus.pc_inc, bus.pc); end
        repeat (2) tick();
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 16'h0040) begin errors++; $display("FAIL flush_empty_out got v=%b pc=%h exp 1 0040", bus.out_valid, bus.out_pc); end
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        bus.out_ready = 1'b1;
        bus.flush = 1'b1;
        load_val = 16'hFFFF;
        tick();
        bus.flush = 1'b0;
        @(negedge clk);
        checks++; if (bus.rom_en !== 1'b1 || bus.rom_addr !== 15'h7FFF) begin errors++; $display("FAIL wrap_addr got en=%b addr=%h exp 1 7fff", bus.rom_en, bus.rom_addr); end
        tick();
        @(negedge clk);
        checks++; if (bus.rom_addr !== 15'h0000) begin errors++; $display("FAIL wrap_addr0 got=%h exp=0000", bus.rom_addr); end
        tick();
        @(negedge clk);
        checks++; if (bus.out_pc !== 16'hFFFF || bus.out_instr !== 16'h80FF) begin errors++; $display("FAIL wrap_out got pc=%h instr=%h exp ffff 80ff", bus.out_pc, bus.out_instr); end
        tick();
        @(negedge clk);
        checks++; if (bus.out_pc !== 16'h0000 || bus.out_instr !== 16'h0100) begin errors++; $display("FAIL wrap_next got pc=%h instr=%h exp 0000 0100", bus.out_pc, bus.out_instr); end
        tick();
    endtask

    typedef struct {
        logic [WORD_W-1:0] pc;
        int                avail;
    } ent_t;

    task automatic test_random();
        ent_t q[$];
        logic ev, ep, ei;
        int pops = 0;
        int stalls = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bus.out_ready = ($urandom_range(3) != 0);
            bus.flush = ($urandom_range(15) == 0);
            load_val = $urandom_range(1) ? 16'($urandom) : 16'hFFFC + 16'($urandom_range(3));
            @(negedge clk);
            ev = !bus.flush && q.size() > 0 && q[0].avail <= c;
            ep = ev && bus.out_ready;
            ei = !bus.flush && (q.size() - int'(ep) < DEPTH);
            checks++; if (bus.out_valid !== ev) begin errors++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, bus.out_valid, ev); end
            checks++; if (bus.pc_inc !== ei || bus.rom_en !== ei) begin errors++; $display("FAIL rnd_issue c=%0d got inc=%b en=%b exp=%b", c, bus.pc_inc, bus.rom_en, ei); end
            if (ei) begin
                checks++; if (bus.rom_addr !== bus.pc[ADDR_W-1:0]) begin errors++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, bus.rom_addr, bus.pc[ADDR_W-1:0]); end
            end
            if (ep) begin
                checks++; if (bus.out_pc !== q[0].pc || bus.out_instr !== rom(q[0].pc[ADDR_W-1:0])) begin errors++; $display("FAIL rnd_data c=%0d got pc=%h instr=%h exp pc=%h instr=%h", c, bus.out_pc, bus.out_instr, q[0].pc, rom(q[0].pc[ADDR_W-1:0])); end
            end
            pops += int'(ep);
            stalls += int'(bus.out_ready && !ev);
            if (bus.flush) q.delete();
            else begin
                if (ep) void'(q.pop_front());
                if (ei) q.push_back('{pc: bus.pc, avail: c + 2});
            end
            tick();
        end
        bus.out_ready = 1'b0;
        bus.flush = 1'b0;
        @(negedge clk);
`ifdef FETCH_PERF_EN
        checks++; if (perf_fetch !== 16'(pops)) begin errors++; $display("FAIL rnd_perf_fetch got=%0d exp=%0d", perf_fetch, pops); end
        checks++; if (perf_stall !== 16'(stalls)) begin errors++; $display("FAIL rnd_perf_stall got=%0d exp=%0d", perf_stall, stalls); end
`endif
        tick();
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        do_reset();
        bus.out_ready = 1'b1;
        repeat (7) tick();
        bus.flush = 1'b1;
        load_val = 16'h0200;
        tick();
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        checks++; if (perf_fetch !== 16'd5) begin errors++; $display("FAIL perf_fetch got=%0d exp=5", perf_fetch); end
        checks++; if (perf_stall !== 16'd3) begin errors++; $display("FAIL perf_stall got=%0d exp=3", perf_stall); end
        tick();
    endtask
`endif

    task automatic test_reset_midrun();
        do_reset();
        bus.out_ready = 1'b1;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0 || bus.pc !== 16'h0000 || bus.pc_inc !== 1'b1) begin errors++; $display("FAIL midrst_state got v=%b pc=%h inc=%b exp 0 0000 1", bus.out_valid, bus.pc, bus.pc_inc); end
`ifdef FETCH_PERF_EN
        checks++; if (perf_fetch !== 16'd0 || perf_stall !== 16'd0) begin errors++; $display("FAIL midrst_perf got=%0d/%0d exp=0/0", perf_fetch, perf_stall); end
`endif
        tick();
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_drop got=%b exp=0", bus.out_valid); end
        tick();
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 16'h0000 || bus.out_instr !== 16'h0100) begin errors++; $display("FAIL midrst_first got v=%b pc=%h instr=%h exp 1 0000 0100", bus.out_valid, bus.out_pc, bus.out_instr); end
        tick();
    endtask

    initial begin
        bus.out_ready = 1'b0;
        bus.flush = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_wrap();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        test_reset_midrun();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
